output_drain_fifo: RTL and testbench

//  Output stage directly downstream of the convolution controller/MAC. Captures each

---
 rtl/output_drain_fifo.sv | 129 ++++++++++++
 tb/tb_output_drain_fifo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/output_drain_fifo.sv
// Output drain FIFO: captures finished output pixels from the convolution
// controller and hands them to the consumer over valid/ready, with a sticky
// drop flag and an end-of-feature-map pulse.
module output_drain_fifo #(
    parameter int ACC_WIDTH          = 32,
    parameter int COORD_WIDTH        = 32,
    parameter int DEPTH              = 4,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64
) (
    input  logic                     clk,
    input  logic                     arst_n_in,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic [ACC_WIDTH-1:0]     in_data,
    input  logic [COORD_WIDTH-1:0]   in_x,
    input  logic [COORD_WIDTH-1:0]   in_y,
    input  logic [COORD_WIDTH-1:0]   in_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_WIDTH-1:0]     out_data,
    output logic [COORD_WIDTH-1:0]   out_x,
    output logic [COORD_WIDTH-1:0]   out_y,
    output logic [COORD_WIDTH-1:0]   out_ch,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic                     all_sent
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ACC_WIDTH + 3 * COORD_WIDTH;
    localparam logic [31:0] TOTAL =
        32'(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS);

    // Each entry is stored as {data, x, y, ch}, forwarded bit-exact.
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        drain_cnt;
    logic               ovf;
    logic               push;
    logic               pop;
    logic               drop;
    logic [ENTRY_W-1:0] head;

    // Status flags, handshake decode and head-entry presentation.
    always_comb begin
        empty     = (cnt == '0);
        full      = (cnt == CNT_W'(DEPTH));
        out_valid = !empty;
        pop       = out_valid && out_ready;
        push      = in_valid && (!full || pop);
        drop      = in_valid && full && !pop;
        head      = empty ? '0 : mem[rd_ptr];
        out_data  = head[ENTRY_W-1 -: ACC_WIDTH];
        out_x     = head[3*COORD_WIDTH-1 -: COORD_WIDTH];
        out_y     = head[2*COORD_WIDTH-1 -: COORD_WIDTH];
        out_ch    = head[COORD_WIDTH-1:0];
        all_sent  = pop && !clear && (drain_cnt == TOTAL - 32'd1);
        count     = cnt;
        overflow  = ovf;
    end

    // Entry storage: written at the tail on an accepted push (no reset needed,
    // contents are only visible through the occupancy count).
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= {in_data, in_x, in_y, in_ch};
        end
    end

    // Pointers and occupancy; clear wins over any same-cycle push/pop.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Sticky drop flag: set when a result arrives with no room for it.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            ovf <= 1'b0;
        end else if (clear) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end
    end

    // Drain counter: counts pops and wraps after the last result of the map so
    // consecutive maps need no clear in between.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            drain_cnt <= '0;
        end else if (clear) begin
            drain_cnt <= '0;
        end else if (pop) begin
            if (drain_cnt == TOTAL - 32'd1) begin
                drain_cnt <= '0;
            end else begin
                drain_cnt <= drain_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_output_drain_fifo.sv
// Directed and scoreboard-checked bench for output_drain_fifo
// (DEPTH=4, feature map 2x1x2 so a map is four results).
module tb_output_drain_fifo;

    logic        clk = 1'b0;
    logic        arst_n_in;
    logic        clear;
    logic        in_valid;
    logic [31:0] in_data, in_x, in_y, in_ch;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data, out_x, out_y, out_ch;
    logic [2:0]  count;
    logic        full, empty, overflow, all_sent;

    int checks   = 0;
    int failures = 0;

    output_drain_fifo #(
        .ACC_WIDTH(32), .COORD_WIDTH(32), .DEPTH(4),
        .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(1), .OUTPUT_NB_CHANNELS(2)
    ) dut (
        .clk(clk), .arst_n_in(arst_n_in), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_x(in_x), .in_y(in_y), .in_ch(in_ch),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_x(out_x), .out_y(out_y), .out_ch(out_ch),
        .count(count), .full(full), .empty(empty), .overflow(overflow), .all_sent(all_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] ch, input logic rdy);
        in_valid  = v;
        in_data   = d;
        in_x      = d + 32'd100;
        in_y      = d + 32'd200;
        in_ch     = ch;
        out_ready = rdy;
    endtask

    task automatic do_clear();
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Stream one feature map (4 results) with the consumer always ready and
    // return how many all_sent pulses were seen and the pop number of the last.
    task automatic stream_map(input logic [31:0] base, output int pulses, output int pulse_pop);
        int pops;
        pops      = 0;
        pulses    = 0;
        pulse_pop = -1;
        for (int c = 0; c < 7; c++) begin
            drive(c < 4, base + 32'(c), 32'(c), 1'b1);
            #1;
            if (out_valid) pops++;
            if (all_sent) begin
                pulses++;
                pulse_pop = pops;
            end
            tick();
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    logic [31:0] q[$];
    logic        m_ovf;
    int          pulses, pulse_pop;

    initial begin
        arst_n_in = 1'b0;
        clear     = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        #3;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_all_sent", all_sent, 0);
        chk("rst_data", out_data, 0);
        #9;
        arst_n_in = 1'b1;

        // Single result becomes visible one cycle after the push.
        drive(1'b1, 32'h11, 32'd5, 1'b0);
        in_x = 32'd0;
        in_y = 32'd0;
        tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 32'h11);
        chk("t1_ch", out_ch, 5);
        chk("t1_x", out_x, 0);
        chk("t1_count", count, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1_empty", empty, 1);

        // Fill, drop a fifth result, then drain in order.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'(i), 32'(i), 1'b0);
            tick();
        end
        chk("t2_full", full, 1);
        chk("t2_count4", count, 4);
        drive(1'b1, 32'd5, 32'd5, 1'b0);
        tick();
        chk("t2_ovf", overflow, 1);
        chk("t2_count_after_drop", count, 4);
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 32'd0, 32'd0, 1'b1);
            chk("t2_order", out_data, 32'(i));
            chk("t2_order_y", out_y, 32'(i) + 32'd200);
            tick();
        end
        out_ready = 1'b0;
        chk("t2_empty", empty, 1);
        chk("t2_ovf_sticky", overflow, 1);

        // Push and pop together while full.
        do_clear();
        chk("t3_clear_ovf", overflow, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h21 + 32'(i), 32'd0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h25, 32'd0, 1'b1);
        tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        chk("t3_count", count, 4);
        chk("t3_ovf", overflow, 0);
        chk("t3_head", out_data, 32'h22);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'd0, 32'd0, 1'b1);
            chk("t3_order", out_data, 32'h22 + 32'(i));
            tick();
        end
        out_ready = 1'b0;
        chk("t3_empty", empty, 1);

        // End-of-map pulse, twice without clear.
        do_clear();
        stream_map(32'h40, pulses, pulse_pop);
        chk("t4_pulses_run1", 64'(pulses), 1);
        chk("t4_pulse_pop_run1", 64'(pulse_pop), 4);
        stream_map(32'h50, pulses, pulse_pop);
        chk("t4_pulses_run2", 64'(pulses), 1);
        chk("t4_pulse_pop_run2", 64'(pulse_pop), 4);

        // Clear beats an in-flight push.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h60 + 32'(i), 32'd0, 1'b0);
            tick();
        end
        drive(1'b0, 32'd0, 32'd0, 1'b1);
        tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        chk("t5_pre_count", count, 3);
        chk("t5_pre_ovf", overflow, 1);
        drive(1'b1, 32'h99, 32'd0, 1'b1);
        clear = 1'b1;
        #1;
        chk("t5_no_pulse_on_clear", all_sent, 0);
        tick();
        clear = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        chk("t5_count", count, 0);
        chk("t5_empty", empty, 1);
        chk("t5_ovf", overflow, 0);
        chk("t5_data", out_data, 0);

        // Random traffic against a queue model.
        m_ovf = 1'b0;
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            logic v, rdy, mpop, mpush;
            logic [31:0] d;
            v   = 1'($urandom_range(0, 1));
            rdy = ($urandom_range(0, 2) != 0) ? 1'b0 : 1'b1;
            if (c > 1500) rdy = 1'($urandom_range(0, 1));
            d   = $urandom;
            drive(v, d, d ^ 32'hA5A5, rdy);
            #1;
            chk("r_count", count, 64'(q.size()));
            chk("r_valid", out_valid, q.size() != 0);
            chk("r_ovf", overflow, m_ovf);
            if (q.size() != 0) begin
                chk("r_data", out_data, q[0]);
                chk("r_x", out_x, q[0] + 32'd100);
                chk("r_ch", out_ch, q[0] ^ 32'hA5A5);
            end
            mpop  = (q.size() != 0) && rdy;
            mpush = v && (q.size() < 4 || mpop);
            if (mpop) void'(q.pop_front());
            if (mpush) q.push_back(d);
            else if (v) m_ovf = 1'b1;
            tick();
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0);

        // Asynchronous reset in the middle of operation.
        drive(1'b1, 32'h77, 32'd0, 1'b0);
        tick();
        #2;
        arst_n_in = 1'b0;
        #1;
        chk("ar_count", count, 0);
        chk("ar_valid", out_valid, 0);
        chk("ar_data", out_data, 0);
        chk("ar_ovf", overflow, 0);
        drive(1'b0, 32'd0, 32'd0, 1'b0);
        #3;
        arst_n_in = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
